genius_seq_player: RTL and testbench
====================================

# genius_seq_player

Parametrised colour-sequence generator and player for the Genius memory game. On a new-game command it fills an internal sequence memory of `DEPTH` colour indices from a seeded LFSR. On a play command it shows the first `level` entries as timed one-hot colour pulses to the lamp/LED driver. A combinational read port returns the expected one-hot colour at any address, so the input checker can compare player presses.

## Interface
Parameters:
- `N_COLORS`, 4: number of colours / one-hot width; legal range 2..8.
- `DEPTH`, 16: sequence length; power of two, 4..256.
- `T_ON`, 8: cycles each colour stays lit; ≥1.
- `T_OFF`, 4: dark cycles after each colour; ≥1.
- Derived: `AW = $clog2(DEPTH)`; `CW = $clog2(N_COLORS)`.

Ports:
- `clk` in 1: single clock. All logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `seed` in 16: LFSR seed, sampled on the `new_game` accept cycle.
- `new_game` in 1: regenerate the sequence; single-cycle request.
- `play` in 1: show the sequence up to `level`; single-cycle request.
- `level` in AW+1: number of entries to show, 0..DEPTH; sampled with `play`.
- `rd_addr` in AW: read-port address.
- `rd_color` out N_COLORS: one-hot colour at `rd_addr`; combinational.
- `color` out N_COLORS: one-hot lamp drive during playback; registered.
- `color_valid` out 1: high while `color` is non-zero.
- `busy` out 1: high in GEN, SHOW_ON and SHOW_OFF.
- `done` out 1: one-cycle pulse at the end of generation or playback.

## Operation
- States are IDLE, GEN, SHOW_ON, SHOW_OFF and FIN.
- Reset values: state IDLE; `color`=0; `color_valid`=0; `busy`=0; `done`=0; step and tick counters 0; LFSR=16'h0001. Sequence memory is not cleared.
- Reset mid-operation aborts immediately to IDLE with the reset values above.
- IDLE:
  - `new_game`: load LFSR with `seed`; a zero seed is replaced by 16'h0001. Go to GEN with address 0.
  - Otherwise `play`: latch `min(level, DEPTH)`. If it is 0, go to FIN. Else go to SHOW_ON at step 0.
  - `new_game` and `play` in the same cycle: `new_game` wins and `play` is dropped.
- GEN:
  - Each cycle write `mem[addr] = lfsr % N_COLORS`, advance the LFSR and increment addr.
  - After writing addr DEPTH-1, go to FIN.
  - LFSR is 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1, shifting right with feedback mask 16'hB400.
- SHOW_ON: `color = 1 << mem[step]` for `T_ON` cycles, then go to SHOW_OFF.
- SHOW_OFF:
  - `color = 0` for `T_OFF` cycles.
  - Then, if step = latched level−1, go to FIN; else step++ and go to SHOW_ON.
- FIN: `done`=1 for one cycle, then IDLE.
- Commands arriving while not in IDLE (including FIN) are ignored and not queued.
- `rd_color = 1 << mem[rd_addr]`. The read port is valid in every state. During GEN it reflects the partially written memory.

## Timing
- `busy` rises the cycle after an accepted command and falls in the FIN cycle, together with `done`.
- Generation: command at cycle 0, GEN at cycles 1..DEPTH, `done` at cycle DEPTH+1.
- Playback of L entries:
  - First `color` appears at cycle 1.
  - Each step lasts T_ON+T_OFF cycles.
  - `done` at cycle L·(T_ON+T_OFF)+1.
- Playback with level 0: `done` at cycle 1, `color` stays 0.
- Back-to-back: a command is accepted in the first IDLE cycle after FIN.
- `color_valid` is the registered OR of `color`, aligned with `color`.

## Configuration
- `GENIUS_FIXED_SEQ_EN`, defined:
  - The GEN state and LFSR are compiled out.
  - `new_game` produces a FIN `done` pulse one cycle later and nothing else.
  - The memory is a constant table. For addresses 0..15 the indices are 0,2,0,3,1,0,3,2,0,1,0,3,2,1,3,0.
  - This mode requires N_COLORS=4 and DEPTH=16.
- Undefined: LFSR-generated memory, as described in Operation.

## Structure
- Package `genius_pkg` holds:
  - the state enum;
  - the LFSR mask constant 16'hB400;
  - the default seed 16'h0001;
  - the fixed 16-entry table.
- Sub-module `genius_lfsr16`: enable, load, seed in; 16-bit state out. It is instantiated only when the macro is undefined.

## Test plan
- Reset during SHOW_ON with level=5 → next cycle `color`=0, `busy`=0, `done`=0, state IDLE.
- Macro defined, `play` with level=4, T_ON=8, T_OFF=4 → `color` sequence 0001,0100,0001,1000, each held 8 cycles with 4 dark cycles after; `done` at cycle 49.
- Macro undefined, `seed`=0 → identical memory contents to `seed`=16'h0001. GEN lasts 16 cycles and `done` is at cycle 17.
- `new_game` and `play` in the same cycle → GEN entered and no colour shown. A `play` issued during GEN is ignored.
- `play` with level=0 → `done` at cycle 1 and `color` stays 0. `play` with level=20 on DEPTH=16 → exactly 16 colours shown.
- After generation, sweep `rd_addr` 0..15 → every `rd_color` is one-hot and matches the colours shown by `play` with level=16.

Source files
------------

// File: rtl/genius_pkg.sv
// genius_pkg: shared state encoding, LFSR constants and the fixed demo sequence.
package genius_pkg;
    typedef enum logic [2:0] {IDLE, GEN, SHOW_ON, SHOW_OFF, FIN} state_t;
    localparam logic [15:0] LFSR_MASK    = 16'hB400;
    localparam logic [15:0] DEFAULT_SEED = 16'h0001;
    // entry i lives in bits [2i+1:2i]: 0,2,0,3,1,0,3,2,0,1,0,3,2,1,3,0
    localparam logic [31:0] FIXED_SEQ    = 32'h36C4_B1C8;
    function automatic logic [1:0] fixed_idx(input logic [3:0] a);
        return FIXED_SEQ[{a, 1'b0} +: 2];
    endfunction
endpackage

// File: rtl/genius_lfsr16.sv
// genius_lfsr16: 16-bit right-shifting Galois LFSR with seed load; a zero seed becomes DEFAULT_SEED.
module genius_lfsr16 import genius_pkg::*; (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        load,
    input  logic [15:0] seed,
    output logic [15:0] state
);
    always_ff @(posedge clk)
        if (rst) state <= DEFAULT_SEED;
        else if (load) state <= (seed == '0) ? DEFAULT_SEED : seed;
        else if (en) state <= (state >> 1) ^ (state[0] ? LFSR_MASK : '0);
endmodule

// File: rtl/genius_seq_player.sv
// genius_seq_player: Genius colour-sequence generator/player; define GENIUS_FIXED_SEQ_EN for the fixed 16-entry table.
module genius_seq_player import genius_pkg::*; #(
    parameter int N_COLORS = 4,
    parameter int DEPTH    = 16,
    parameter int T_ON     = 8,
    parameter int T_OFF    = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [15:0]              seed,
    input  logic                     new_game,
    input  logic                     play,
    input  logic [$clog2(DEPTH):0]   level,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [N_COLORS-1:0]      rd_color,
    output logic [N_COLORS-1:0]      color,
    output logic                     color_valid,
    output logic                     busy,
    output logic                     done
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(N_COLORS);
    localparam int TW = $clog2((T_ON > T_OFF ? T_ON : T_OFF) + 1);

    state_t                state, state_n;
    logic [AW-1:0]         step, step_n;
    logic [TW-1:0]         tick, tick_n;
    logic [AW:0]           lvl, lvl_n;
    logic [N_COLORS-1:0]   color_n;
    logic [CW-1:0]         rd_idx, show_idx;

`ifdef GENIUS_FIXED_SEQ_EN
    assign rd_idx   = CW'(fixed_idx(4'(rd_addr)));
    assign show_idx = CW'(fixed_idx(4'(step_n)));
`else
    logic [CW-1:0] mem [DEPTH];
    logic [AW-1:0] addr;
    logic [15:0]   lfsr;
    genius_lfsr16 u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .en   (state == GEN),
        .load (state == IDLE && new_game),
        .seed (seed),
        .state(lfsr)
    );
    always_ff @(posedge clk)
        if (state == GEN) mem[addr] <= CW'(lfsr % 16'(N_COLORS));
    always_ff @(posedge clk)
        addr <= (rst || state != GEN) ? '0 : addr + 1'b1;
    assign rd_idx   = mem[rd_addr];
    assign show_idx = mem[step_n];
`endif

    always_comb begin
        state_n = state;
        step_n  = step;
        tick_n  = tick;
        lvl_n   = lvl;
        case (state)
            IDLE:
                if (new_game) begin
`ifdef GENIUS_FIXED_SEQ_EN
                    state_n = FIN;
`else
                    state_n = GEN;
`endif
                end else if (play) begin
                    lvl_n   = (level > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : level;
                    step_n  = '0;
                    tick_n  = '0;
                    state_n = (lvl_n == '0) ? FIN : SHOW_ON;
                end
`ifndef GENIUS_FIXED_SEQ_EN
            GEN:
                if (addr == AW'(DEPTH - 1)) state_n = FIN;
`endif
            SHOW_ON:
                if (tick == TW'(T_ON - 1)) begin
                    tick_n  = '0;
                    state_n = SHOW_OFF;
                end else tick_n = tick + 1'b1;
            SHOW_OFF:
                if (tick == TW'(T_OFF - 1)) begin
                    tick_n = '0;
                    if ({1'b0, step} == lvl - 1'b1) state_n = FIN;
                    else begin
                        step_n  = step + 1'b1;
                        state_n = SHOW_ON;
                    end
                end else tick_n = tick + 1'b1;
            default: state_n = IDLE;
        endcase
        color_n = (state_n == SHOW_ON) ? N_COLORS'(1) << show_idx : '0;
    end

    always_ff @(posedge clk)
        if (rst) begin
            state       <= IDLE;
            step        <= '0;
            tick        <= '0;
            lvl         <= '0;
            color       <= '0;
            color_valid <= 1'b0;
        end else begin
            state       <= state_n;
            step        <= step_n;
            tick        <= tick_n;
            lvl         <= lvl_n;
            color       <= color_n;
            color_valid <= |color_n;
        end

    assign busy     = state inside {GEN, SHOW_ON, SHOW_OFF};
    assign done     = state == FIN;
    assign rd_color = N_COLORS'(1) << rd_idx;
endmodule

// File: tb/tb_genius_seq_player.sv
// tb_genius_seq_player: randomized self-checking bench against a sequence/timing model of the player.
module tb_genius_seq_player;
    localparam int DEPTH = 16;
    localparam int STEP  = 12;
`ifdef GENIUS_FIXED_SEQ_EN
    localparam int GEN_DONE = 1;
`else
    localparam int GEN_DONE = DEPTH + 1;
`endif

    logic        clk = 0, rst = 1, new_game = 0, play = 0;
    logic [15:0] seed = 0;
    logic [4:0]  level = 0;
    logic [3:0]  rd_addr = 0;
    logic [3:0]  rd_color, color;
    logic        color_valid, busy, done;
    int          n_cmp = 0, n_bad = 0;
    int          model [DEPTH];

    genius_seq_player dut (
        .clk(clk), .rst(rst), .seed(seed), .new_game(new_game), .play(play),
        .level(level), .rd_addr(rd_addr), .rd_color(rd_color), .color(color),
        .color_valid(color_valid), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic gen_model(input logic [15:0] s);
`ifdef GENIUS_FIXED_SEQ_EN
        int tbl [DEPTH] = '{0,2,0,3,1,0,3,2,0,1,0,3,2,1,3,0};
        model = tbl;
`else
        logic [15:0] r = (s == 0) ? 16'h0001 : s;
        for (int i = 0; i < DEPTH; i++) begin
            model[i] = int'(r % 16'd4);
            r = r[0] ? ((r >> 1) ^ 16'hB400) : (r >> 1);
        end
`endif
    endtask

    function automatic logic [3:0] exp_col(input int c, input int lvl);
        if (c >= 1 && c <= lvl * STEP && (c - 1) % STEP < 8) return 4'(1 << model[(c - 1) / STEP]);
        return 4'b0;
    endfunction

    task automatic cmd(input bit ng, input bit pl, input int lv, input logic [15:0] sd);
        @(negedge clk);
        new_game = ng; play = pl; level = 5'(lv); seed = sd;
        @(posedge clk); #1;
        new_game = 0; play = 0;
    endtask

    task automatic watch(input int c0, input int lvl, input int want_done, input int want_shown, input string name);
        int at = -1, bad = 0, shown = 0;
        logic busy_at_done = 1'bx;
        logic [3:0] prev = 0, e;
        for (int c = c0; c <= want_done + 20; c++) begin
            e = exp_col(c, lvl);
            if (color !== e || color_valid !== (e != 0)) begin
                if (bad == 0) $display("  %s first colour diff at cycle %0d: got %b/%b want %b", name, c, color, color_valid, e);
                bad++;
            end
            if (color != 0 && prev == 0) shown++;
            prev = color;
            if (done === 1'b1) begin at = c; busy_at_done = busy; break; end
            @(posedge clk); #1;
        end
        n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL %s colour: %0d bad cycles, want 0", name, bad); end
        n_cmp++; if (at != want_done) begin n_bad++; $display("FAIL %s done cycle: got %0d want %0d", name, at, want_done); end
        n_cmp++; if (shown != want_shown) begin n_bad++; $display("FAIL %s colours shown: got %0d want %0d", name, shown, want_shown); end
        n_cmp++; if (busy_at_done !== 1'b0) begin n_bad++; $display("FAIL %s busy at done: got %b want 0", name, busy_at_done); end
        @(posedge clk); #1;
    endtask

    task automatic sweep(input string name);
        for (int a = 0; a < DEPTH; a++) begin
            rd_addr = 4'(a); #1;
            n_cmp++;
            if (rd_color !== 4'(1 << model[a]) || $countones(rd_color) != 1) begin
                n_bad++; $display("FAIL %s rd_color[%0d]: got %b want %b", name, a, rd_color, 4'(1 << model[a]));
            end
        end
    endtask

    task automatic gen(input logic [15:0] s, input string name);
        cmd(1, 0, 0, s);
        n_cmp++; if (busy !== (GEN_DONE > 1)) begin n_bad++; $display("FAIL %s busy cycle1: got %b want %b", name, busy, GEN_DONE > 1); end
        watch(1, 0, GEN_DONE, 0, name);
        gen_model(s);
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk); #1;
        n_cmp++; if ({color, color_valid, busy, done} !== 7'b0) begin
            n_bad++; $display("FAIL reset outputs: got %b want 0000000", {color, color_valid, busy, done});
        end
        @(negedge clk); rst = 0;
        @(posedge clk); #1;
    endtask

    task automatic test_seed_zero();
        gen(16'h0000, "gen_seed0");
        sweep("seed0");
        gen(16'h0001, "gen_seed1");
        sweep("seed1");
    endtask

    task automatic test_random_play();
        for (int i = 0; i < 3; i++) begin
            int l = $urandom_range(1, 6);
            gen(16'($urandom), "gen_rand");
            sweep("rand");
            cmd(0, 1, l, 0);
            n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL play busy: got %b want 1", busy); end
            watch(1, l, l * STEP + 1, l, "play_rand");
        end
    endtask

    task automatic test_levels();
        cmd(0, 1, 0, 0);
        watch(1, 0, 1, 0, "level0");
        cmd(0, 1, 20, 0);
        watch(1, DEPTH, DEPTH * STEP + 1, DEPTH, "level20");
    endtask

    task automatic test_collision();
        logic [15:0] s = 16'($urandom) | 16'h0100;
        cmd(1, 1, 3, s);
        @(negedge clk); play = 1; level = 5'd3;
        @(posedge clk); #1; play = 0;
        watch(2, 0, GEN_DONE, 0, "collision");
        gen_model(s);
        sweep("collision");
    endtask

    task automatic test_reset_mid();
        cmd(0, 1, 5, 0);
        repeat (3) begin @(posedge clk); #1; end
        @(negedge clk); rst = 1;
        @(posedge clk); #1;
        n_cmp++; if ({color, color_valid, busy, done} !== 7'b0) begin
            n_bad++; $display("FAIL reset_mid outputs: got %b want 0000000", {color, color_valid, busy, done});
        end
        @(negedge clk); rst = 0;
        cmd(0, 1, 1, 0);
        watch(1, 1, STEP + 1, 1, "post_reset");
    endtask

    task automatic test_back_to_back();
        cmd(0, 1, 2, 0);
        watch(1, 2, 2 * STEP + 1, 2, "b2b_first");
        cmd(0, 1, 3, 0);
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL b2b accept: busy got %b want 1", busy); end
        watch(1, 3, 3 * STEP + 1, 3, "b2b_second");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global timeout: run did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_seed_zero();
        test_random_play();
        test_levels();
        test_collision();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
